// File: rtl/inbuf_fifo_if.sv
// Host, controller and engine signals of the input-buffer line FIFO.
// master = host/controller/engine side, slave = the FIFO itself.
interface inbuf_fifo_if #(
   parameter int LINE_W = 1024,
   parameter int CNT_W  = 5
);
   logic              host_inbuf_wr_en;
   logic [LINE_W-1:0] host_inbuf_wr_data;
   logic              inbuf_host_full;
   logic              inbuf_host_almost_full;
   logic              cntl_inbuf_fifo_rd_rq;
   logic              cntl_inbuf_fifo_mem_en;
   logic              inbuf_fifo_cntl_empty;
   logic [LINE_W-1:0] inbuf_fifo_eng_data;
   logic              inbuf_fifo_eng_data_vld;
   logic [CNT_W-1:0]  inbuf_fifo_count;
   logic              inbuf_fifo_ovf;
   logic              inbuf_fifo_udf;

   modport master (
      output host_inbuf_wr_en, host_inbuf_wr_data,
      output cntl_inbuf_fifo_rd_rq, cntl_inbuf_fifo_mem_en,
      input  inbuf_host_full, inbuf_host_almost_full, inbuf_fifo_cntl_empty,
      input  inbuf_fifo_eng_data, inbuf_fifo_eng_data_vld, inbuf_fifo_count,
      input  inbuf_fifo_ovf, inbuf_fifo_udf
   );

   modport slave (
      input  host_inbuf_wr_en, host_inbuf_wr_data,
      input  cntl_inbuf_fifo_rd_rq, cntl_inbuf_fifo_mem_en,
      output inbuf_host_full, inbuf_host_almost_full, inbuf_fifo_cntl_empty,
      output inbuf_fifo_eng_data, inbuf_fifo_eng_data_vld, inbuf_fifo_count,
      output inbuf_fifo_ovf, inbuf_fifo_udf
   );
endinterface

// File: rtl/inbuf_fifo.sv
// Input-buffer line FIFO: host writes whole lines, controller pops one line at a time,
// popped line is registered towards the encode engine (1-cycle read latency).
module inbuf_fifo #(
   parameter int K_MAX         = 128,
   parameter int W             = 4,
   parameter int PACKET_LENGTH = 2,
   parameter int DEPTH         = 16,
   parameter int AFULL_TH      = 2
) (
   input logic          clk,
   input logic          rstn,
   input logic          eng_rstn,
   inbuf_fifo_if.slave  bus
);
   localparam int LINE_W = K_MAX * W * PACKET_LENGTH;
   localparam int PTR_W  = $clog2(DEPTH);
   localparam int CNT_W  = $clog2(DEPTH + 1);

   logic [LINE_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [CNT_W-1:0]  count_q;
   logic [CNT_W-1:0]  count_nxt;
   logic              empty_q;
   logic              full_q;
   logic              afull_q;
   logic              vld_q;
   logic              ovf_q;
   logic              udf_q;
   logic [LINE_W-1:0] data_q;
   logic              rd_req;
   logic              rd_acc;
   logic              wr_acc;
   logic              afull_nxt;

   // A pop frees its slot in the same cycle, so a full FIFO still accepts a write alongside a pop.
   always_comb begin
      rd_req    = bus.cntl_inbuf_fifo_rd_rq & bus.cntl_inbuf_fifo_mem_en;
      rd_acc    = rd_req & ~empty_q;
      wr_acc    = bus.host_inbuf_wr_en & (~full_q | rd_acc);
      count_nxt = count_q + CNT_W'(wr_acc) - CNT_W'(rd_acc);
      afull_nxt = (DEPTH - int'(count_nxt)) <= AFULL_TH;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
         empty_q <= 1'b1;
         full_q  <= 1'b0;
         afull_q <= 1'b0;
         vld_q   <= 1'b0;
         data_q  <= '0;
         ovf_q   <= 1'b0;
         udf_q   <= 1'b0;
      end else if (!eng_rstn) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
         empty_q <= 1'b1;
         full_q  <= 1'b0;
         afull_q <= 1'b0;
         vld_q   <= 1'b0;
         data_q  <= '0;
         ovf_q   <= 1'b0;
         udf_q   <= 1'b0;
      end else begin
         if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
         if (rd_acc) begin
            rd_ptr <= rd_ptr + 1'b1;
            data_q <= mem[rd_ptr];
         end
         vld_q   <= rd_acc;
         count_q <= count_nxt;
         empty_q <= (count_nxt == '0);
         full_q  <= (count_nxt == CNT_W'(DEPTH));
         afull_q <= afull_nxt;
         if (bus.host_inbuf_wr_en & full_q & ~rd_acc) ovf_q <= 1'b1;
         if (rd_req & empty_q) udf_q <= 1'b1;
      end
   end

   // Storage is never cleared; flush only rewinds the pointers.
   always_ff @(posedge clk) begin
      if (eng_rstn && wr_acc) mem[wr_ptr] <= bus.host_inbuf_wr_data;
   end

   assign bus.inbuf_host_full         = full_q;
   assign bus.inbuf_host_almost_full  = afull_q;
   assign bus.inbuf_fifo_cntl_empty   = empty_q;
   assign bus.inbuf_fifo_eng_data     = data_q;
   assign bus.inbuf_fifo_eng_data_vld = vld_q;
   assign bus.inbuf_fifo_count        = count_q;
   assign bus.inbuf_fifo_ovf          = ovf_q;
   assign bus.inbuf_fifo_udf          = udf_q;
endmodule

// File: tb/tb_inbuf_fifo.sv
// Bench for inbuf_fifo: queue-based reference model feeding a scoreboard, checked by an
// independent negedge monitor, plus directed corner cases and randomized traffic.
module tb_inbuf_fifo;
   localparam int DEPTH    = 16;
   localparam int AFULL_TH = 2;
   localparam int LINE_W   = 1024;
   localparam int CNT_W    = 5;
   typedef logic [LINE_W-1:0] line_t;

   logic clk = 1'b0;
   logic rstn = 1'b0;
   logic eng_rstn = 1'b1;
   int   total = 0;
   int   bad = 0;
   bit   mon_on = 1'b0;

   inbuf_fifo_if #(.LINE_W(LINE_W), .CNT_W(CNT_W)) bus ();

   inbuf_fifo #(.K_MAX(128), .W(4), .PACKET_LENGTH(2), .DEPTH(DEPTH), .AFULL_TH(AFULL_TH)) dut (
      .clk(clk), .rstn(rstn), .eng_rstn(eng_rstn), .bus(bus)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   line_t m_q[$];
   line_t exp_q[$];
   line_t exp_last = '0;
   bit    exp_vld = 1'b0;
   bit    m_ovf = 1'b0;
   bit    m_udf = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic chk_line(input string nm, input line_t act, input line_t exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got low word %h expected low word %h at %0t", nm, act[63:0], exp[63:0], $time);
      end
   endtask

   function automatic line_t mk_line(input int tag, input bit rnd);
      line_t l;
      logic [31:0] t;
      t = tag;
      for (int k = 0; k < LINE_W / 32; k++) begin
         logic [31:0] kk;
         kk = k;
         l[k*32 +: 32] = rnd ? $urandom : {t[15:0], kk[15:0]};
      end
      return l;
   endfunction

   // Reference model: a plain queue of stored lines, sticky error bits and the popped-line stream.
   always @(posedge clk or negedge rstn) begin
      bit rd_ok;
      bit wr_ok;
      bit rd_try;
      if (!rstn || !eng_rstn) begin
         m_q.delete();
         exp_q.delete();
         exp_vld  = 1'b0;
         exp_last = '0;
         m_ovf    = 1'b0;
         m_udf    = 1'b0;
      end else begin
         rd_try = bus.cntl_inbuf_fifo_rd_rq && bus.cntl_inbuf_fifo_mem_en;
         rd_ok  = rd_try && (m_q.size() > 0);
         wr_ok  = bus.host_inbuf_wr_en && ((m_q.size() < DEPTH) || rd_ok);
         if (rd_try && m_q.size() == 0) m_udf = 1'b1;
         if (bus.host_inbuf_wr_en && m_q.size() == DEPTH && !rd_ok) m_ovf = 1'b1;
         exp_vld = rd_ok;
         if (rd_ok) begin
            exp_last = m_q.pop_front();
            exp_q.push_back(exp_last);
         end
         if (wr_ok) m_q.push_back(bus.host_inbuf_wr_data);
      end
   end

   always @(negedge clk) begin
      if (mon_on) begin
         chk("count", 32'(bus.inbuf_fifo_count), m_q.size());
         chk("empty", 32'(bus.inbuf_fifo_cntl_empty), 32'(m_q.size() == 0));
         chk("full", 32'(bus.inbuf_host_full), 32'(m_q.size() == DEPTH));
         chk("almost_full", 32'(bus.inbuf_host_almost_full), 32'((DEPTH - m_q.size()) <= AFULL_TH));
         chk("ovf", 32'(bus.inbuf_fifo_ovf), 32'(m_ovf));
         chk("udf", 32'(bus.inbuf_fifo_udf), 32'(m_udf));
         chk("data_vld", 32'(bus.inbuf_fifo_eng_data_vld), 32'(exp_vld));
         if (bus.inbuf_fifo_eng_data_vld) begin
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL scoreboard: got vld with data %h expected no line at %0t",
                        bus.inbuf_fifo_eng_data[63:0], $time);
            end else begin
               chk_line("pop_data", bus.inbuf_fifo_eng_data, exp_q.pop_front());
            end
         end else begin
            if (exp_vld && exp_q.size() > 0) void'(exp_q.pop_front());
            chk_line("held_data", bus.inbuf_fifo_eng_data, exp_last);
         end
      end
   end

   task automatic idle();
      bus.host_inbuf_wr_en      = 1'b0;
      bus.cntl_inbuf_fifo_rd_rq = 1'b0;
      bus.cntl_inbuf_fifo_mem_en = 1'b0;
   endtask

   task automatic step(input bit wr, input bit rd, input bit me, input line_t d);
      bus.host_inbuf_wr_en       = wr;
      bus.host_inbuf_wr_data     = d;
      bus.cntl_inbuf_fifo_rd_rq  = rd;
      bus.cntl_inbuf_fifo_mem_en = me;
      @(posedge clk);
      @(negedge clk);
      idle();
   endtask

   initial begin
      line_t l;
      line_t last_new;
      idle();
      bus.host_inbuf_wr_data = '0;
      repeat (2) @(negedge clk);
      rstn = 1'b1;
      mon_on = 1'b1;
      chk("rst_count", 32'(bus.inbuf_fifo_count), 0);
      chk("rst_empty", 32'(bus.inbuf_fifo_cntl_empty), 1);
      chk("rst_vld", 32'(bus.inbuf_fifo_eng_data_vld), 0);

      // Fill 0..15, then drain back-to-back
      for (int i = 0; i < DEPTH; i++) begin
         step(1, 0, 1, mk_line(i, 0));
         if (i == 12) chk("afull_at13", 32'(bus.inbuf_host_almost_full), 0);
         if (i == 13) chk("afull_at14", 32'(bus.inbuf_host_almost_full), 1);
         if (i == 14) chk("full_at15", 32'(bus.inbuf_host_full), 0);
      end
      chk("fill_full", 32'(bus.inbuf_host_full), 1);
      chk("fill_count", 32'(bus.inbuf_fifo_count), DEPTH);
      for (int i = 0; i < DEPTH; i++) begin
         step(0, 1, 1, '0);
         chk("drain_vld", 32'(bus.inbuf_fifo_eng_data_vld), 1);
         chk_line("drain_order", bus.inbuf_fifo_eng_data, mk_line(i, 0));
      end
      chk("drain_empty", 32'(bus.inbuf_fifo_cntl_empty), 1);
      step(0, 0, 0, '0);
      chk("vld_drop", 32'(bus.inbuf_fifo_eng_data_vld), 0);

      // Full with simultaneous read/write, then overflow
      for (int i = 0; i < DEPTH; i++) step(1, 0, 1, mk_line(0, 1));
      last_new = mk_line(0, 1);
      step(1, 1, 1, last_new);
      chk("full_rw_count", 32'(bus.inbuf_fifo_count), DEPTH);
      chk("full_rw_ovf", 32'(bus.inbuf_fifo_ovf), 0);
      step(1, 0, 1, mk_line(0, 1));
      chk("ovf_set", 32'(bus.inbuf_fifo_ovf), 1);
      chk("ovf_count", 32'(bus.inbuf_fifo_count), DEPTH);
      for (int i = 0; i < DEPTH; i++) step(0, 1, 1, '0);
      chk_line("new_line_last", bus.inbuf_fifo_eng_data, last_new);

      // Empty corner: write and pop together
      l = mk_line(0, 1);
      step(1, 1, 1, l);
      chk("empty_rw_count", 32'(bus.inbuf_fifo_count), 1);
      chk("empty_rw_udf", 32'(bus.inbuf_fifo_udf), 1);
      chk("empty_rw_vld", 32'(bus.inbuf_fifo_eng_data_vld), 0);
      step(0, 1, 1, '0);
      chk_line("empty_rw_pop", bus.inbuf_fifo_eng_data, l);

      // Flush with 5 lines queued; traffic in the flush cycle is dropped
      for (int i = 0; i < 5; i++) step(1, 0, 1, mk_line(0, 1));
      eng_rstn = 1'b0;
      step(1, 1, 1, mk_line(0, 1));
      eng_rstn = 1'b1;
      chk("flush_count", 32'(bus.inbuf_fifo_count), 0);
      chk("flush_empty", 32'(bus.inbuf_fifo_cntl_empty), 1);
      chk("flush_udf", 32'(bus.inbuf_fifo_udf), 0);
      chk("flush_ovf", 32'(bus.inbuf_fifo_ovf), 0);

      // mem_en gating
      step(1, 0, 1, mk_line(0, 1));
      step(1, 0, 1, mk_line(0, 1));
      step(0, 1, 0, '0);
      chk("gate_count", 32'(bus.inbuf_fifo_count), 2);
      chk("gate_vld", 32'(bus.inbuf_fifo_eng_data_vld), 0);
      chk("gate_udf", 32'(bus.inbuf_fifo_udf), 0);

      // Async reset in the middle of a cycle with traffic applied
      step(1, 0, 1, mk_line(0, 1));
      bus.host_inbuf_wr_en       = 1'b1;
      bus.host_inbuf_wr_data     = mk_line(0, 1);
      bus.cntl_inbuf_fifo_rd_rq  = 1'b1;
      bus.cntl_inbuf_fifo_mem_en = 1'b1;
      @(posedge clk);
      #2;
      rstn = 1'b0;
      #1;
      chk("arst_count", 32'(bus.inbuf_fifo_count), 0);
      chk("arst_empty", 32'(bus.inbuf_fifo_cntl_empty), 1);
      chk("arst_vld", 32'(bus.inbuf_fifo_eng_data_vld), 0);
      chk("arst_full", 32'(bus.inbuf_host_full), 0);
      chk_line("arst_data", bus.inbuf_fifo_eng_data, '0);
      @(negedge clk);
      idle();
      rstn = 1'b1;

      // Random traffic: write-biased then read-biased so pointers wrap through full and empty
      for (int i = 0; i < 300; i++) begin
         int wp;
         wp = (i % 100 < 50) ? 70 : 35;
         step($urandom_range(0, 99) < wp, $urandom_range(0, 99) < 55,
              $urandom_range(0, 99) < 85, mk_line(0, 1));
         total++;
         if (bus.inbuf_fifo_count > CNT_W'(DEPTH)) begin
            bad++;
            $display("FAIL count_bound: got %0d expected at most %0d", bus.inbuf_fifo_count, DEPTH);
         end
      end
      for (int i = 0; i < DEPTH + 1; i++) step(0, 1, 1, '0);
      step(0, 0, 0, '0);
      chk("scoreboard_left", exp_q.size(), 0);

      mon_on = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
